// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    modport master (input ihit, imemload, output imemREN, imemaddr);
    modport slave  (output ihit, imemload, input imemREN, imemaddr);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, one-entry hold buffer for decode back-pressure, redirect and halt.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic               CLK,
    input  logic               nRST,
    fetch_unit_if.master       bus,
    input  logic               stall,
    input  logic               pc_redirect,
    input  logic [31:0]        redirect_addr,
    input  logic               halt,
    output logic [31:0]        instr_out,
    output logic [31:0]        npc_out,
    output logic               instr_valid
`ifdef FETCH_PERF_EN
   ,output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_inc;
    logic [31:0] buf_instr, buf_instr_n, buf_npc, buf_npc_n;
    logic [31:0] instr_n, npc_n;
    logic        valid_n;
    logic        accept;

    assign pc_inc       = pc + 32'd4;
    assign bus.imemaddr = pc;
    assign bus.imemREN  = (state == FETCH);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            instr_out   <= '0;
            npc_out     <= '0;
            instr_valid <= 1'b0;
            buf_instr   <= '0;
            buf_npc     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_out   <= instr_n;
            npc_out     <= npc_n;
            instr_valid <= valid_n;
            buf_instr   <= buf_instr_n;
            buf_npc     <= buf_npc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_n     = instr_out;
        npc_n       = npc_out;
        valid_n     = instr_valid;
        buf_instr_n = buf_instr;
        buf_npc_n   = buf_npc;
        accept      = 1'b0;
        if (state != HALTED) begin
            // Redirect beats halt, which beats normal ihit/stall handling.
            if (pc_redirect) begin
                pc_n        = redirect_addr & ~32'h3;
                buf_instr_n = '0;
                buf_npc_n   = '0;
                valid_n     = 1'b0;
                state_n     = FETCH;
            end else if (halt) begin
                valid_n = 1'b0;
                state_n = HALTED;
            end else if (state == FETCH) begin
                if (bus.ihit) begin
                    accept = 1'b1;
                    pc_n   = pc_inc;
                    if (stall) begin
                        buf_instr_n = bus.imemload;
                        buf_npc_n   = pc_inc;
                        state_n     = HOLD;
                    end else begin
                        instr_n = bus.imemload;
                        npc_n   = pc_inc;
                        valid_n = 1'b1;
                    end
                end else if (!stall) begin
                    valid_n = 1'b0;
                end
            end else if (!stall) begin
                instr_n = buf_instr;
                npc_n   = buf_npc;
                valid_n = 1'b1;
                state_n = FETCH;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (accept)
                fetch_count <= fetch_count + 32'd1;
            if (stall && state != HALTED)
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, reset value of the program counter.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 ihit  input  1  instruction memory has returned imemload for imemaddr this cycle.
REQ-005 imemload  input  32  instruction word from memory, valid only when ihit=1.
REQ-006 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-007 pc_redirect  input  1  branch/jump taken; restart fetch at redirect_addr.
REQ-008 redirect_addr  input  32  target PC for pc_redirect.
REQ-009 halt  input  1  decoded HALT; stop fetching permanently until reset.
REQ-010 imemREN  output  1  instruction read request.
REQ-011 imemaddr  output  32  current PC driven to instruction memory.
REQ-012 instr_out  output  32  registered instruction presented to decode (opcode/funct source).
REQ-013 npc_out  output  32  registered PC+4 of instr_out.
REQ-014 instr_valid  output  1  instr_out is a real instruction, not a bubble.

Function
REQ-015 States: FETCH, HOLD, HALTED; exactly one one-entry hold buffer (instr, npc).
REQ-016 imemaddr SHALL equal the PC register at all times; imemREN=1 only in FETCH, 0 in HOLD and HALTED.
REQ-017 Priority per cycle: pc_redirect > halt > ihit/stall handling.
REQ-018 FETCH, ihit=1, stall=0: instr_out<=imemload, npc_out<=PC+4, instr_valid<=1, PC<=PC+4 (one-cycle latency from ihit to output).
REQ-019 FETCH, ihit=1, stall=1: buffer<=(imemload, PC+4), PC<=PC+4, outputs held, go HOLD.
REQ-020 FETCH, ihit=0, stall=0: instr_valid<=0 (bubble), instr_out/npc_out held, PC held.
REQ-021 FETCH, ihit=0, stall=1: all outputs and PC held.
REQ-022 HOLD, stall=1: hold; ihit ignored. HOLD, stall=0: outputs<=buffer, instr_valid<=1, go FETCH.
REQ-023 pc_redirect=1 in any non-HALTED state: PC<={redirect_addr[31:2],2'b00}, buffer discarded, instr_valid<=0, go FETCH; a same-cycle ihit is discarded.
REQ-024 halt=1 (no redirect): go HALTED, PC frozen, instr_valid<=0; HALTED exited only by nRST.
REQ-025 PC addition wraps modulo 2^32 (32'hFFFFFFFC+4 = 32'h00000000).

Reset
REQ-026 nRST low SHALL immediately set PC=PC_INIT, instr_out=0, npc_out=0, instr_valid=0, buffer cleared, state FETCH, regardless of state or pending ihit.
REQ-027 First cycle after nRST release: imemREN=1, imemaddr=PC_INIT.

Configuration
REQ-028 Macro FETCH_PERF_EN: when defined, add outputs fetch_count[31:0] (increments on each accepted ihit, REQ-018/019) and stall_count[31:0] (increments each cycle stall=1 while not HALTED), both reset to 0, wrap at 2^32.
REQ-029 Without FETCH_PERF_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset, ihit=1 each cycle, imemload=32'h24010005 then 32'h24020007 -> instr_out sequence 24010005, 24020007; npc_out 4, 8; imemaddr 0,4,8.
REQ-031 ihit=1 with stall=1 for 3 cycles at PC=8, word 32'h00221820 -> state HOLD, imemREN=0, outputs held; cycle after stall drops instr_out=00221820, npc_out=12, instr_valid=1.
REQ-032 pc_redirect=1, redirect_addr=32'h00000043, same-cycle ihit -> next imemaddr=32'h00000040, instr_valid=0, ihit word dropped.
REQ-033 halt=1 at PC=32'h10 -> imemREN=0, imemaddr stays 32'h10 for 10+ cycles despite ihit; nRST pulse -> imemaddr=PC_INIT.
REQ-034 PC=32'hFFFFFFFC, ihit=1 -> imemaddr=0, npc_out=0.
REQ-035 FETCH_PERF_EN build: 5 accepted fetches, 2 stall cycles -> fetch_count=5, stall_count=2; nRST mid-HOLD -> both 0, instr_valid=0.
